// File: rtl/zap_uart_stim_tx.sv
// zap_uart_stim_tx: self-timed UART stimulus transmitter.
// Queues bytes in a FIFO and sends them on o_txd with a programmable frame format.
// Ports:
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_dat, i_valid      byte to queue, push request
//   o_ready             FIFO has room (push = i_valid & o_ready)
//   o_txd               serial line, idles high
//   o_busy              frame in flight
//   o_empty             FIFO empty and no frame in flight
//   o_frames_sent       completed frames, saturating
module zap_uart_stim_tx #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          DATA_BITS    = 8,
    parameter int          PARITY_EN    = 0,
    parameter int          PARITY_ODD   = 0,
    parameter int          STOP_BITS    = 1,
    parameter int          FIFO_DEPTH   = 16,
    parameter int          IDLE_BITS    = 255,
    // reset value of o_frames_sent; 0 for normal use
    parameter logic [15:0] FRAMES_INIT  = 16'h0000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [DATA_BITS-1:0] i_dat,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_txd,
    output logic                 o_busy,
    output logic                 o_empty,
    output logic [15:0]          o_frames_sent
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int HW = $clog2(IDLE_BITS + 2);

    localparam logic [TW-1:0] T_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [HW-1:0] H_LAST  =
        HW'((IDLE_BITS > 0) ? IDLE_BITS - 1 : 0);
    localparam logic [2:0]    D_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0]    S_LAST  = 3'(STOP_BITS - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic          ODD     = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_HOLD,
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    localparam state_t RESET_ST = (IDLE_BITS == 0) ? S_IDLE : S_HOLD;

    // FIFO
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_nxt;
    logic                 push;
    logic                 pop;
    logic                 fifo_nonempty;
    logic [DATA_BITS-1:0] head;

    // Transmitter
    state_t               state_q;
    state_t               state_d;
    logic [TW-1:0]        timer_q;
    logic [TW-1:0]        timer_d;
    logic [2:0]           bit_q;
    logic [2:0]           bit_d;
    logic [HW-1:0]        hold_q;
    logic [HW-1:0]        hold_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic                 par_q;
    logic                 par_d;
    logic                 txd_d;
    logic                 busy_d;
    logic                 frame_done;
    logic                 boundary;

    assign o_ready       = (count < DEPTH_C);
    assign push          = i_valid & o_ready;
    assign fifo_nonempty = (count != '0);
    assign head          = mem[rd_ptr];
    assign boundary      = (timer_q == T_LAST);

    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_dat;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = boundary ? '0 : timer_q + 1'b1;
        bit_d      = bit_q;
        hold_d     = hold_q;
        shift_d    = shift_q;
        par_d      = par_q;
        txd_d      = o_txd;
        busy_d     = o_busy;
        pop        = 1'b0;
        frame_done = 1'b0;

        unique case (state_q)
            S_HOLD: begin
                txd_d = 1'b1;
                if (boundary) begin
                    if (hold_q == H_LAST) begin
                        hold_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            S_IDLE: begin
                // timer stays at 0 so the start bit gets a full period
                timer_d = '0;
                txd_d   = 1'b1;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                    shift_d = head;
                    par_d   = (^head) ^ ODD;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (boundary) begin
                    txd_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (boundary) begin
                    if (bit_q == D_LAST) begin
                        bit_d = '0;
                        if (PARITY_EN != 0) begin
                            txd_d   = par_q;
                            state_d = S_PAR;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        txd_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_PAR: begin
                if (boundary) begin
                    txd_d   = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (boundary) begin
                    if (bit_q == S_LAST) begin
                        bit_d      = '0;
                        frame_done = 1'b1;
                        // chain the next frame with no idle gap
                        if (fifo_nonempty) begin
                            pop     = 1'b1;
                            txd_d   = 1'b0;
                            shift_d = head;
                            par_d   = (^head) ^ ODD;
                            state_d = S_START;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= RESET_ST;
            timer_q       <= '0;
            bit_q         <= '0;
            hold_q        <= '0;
            shift_q       <= '0;
            par_q         <= 1'b0;
            o_txd         <= 1'b1;
            o_busy        <= 1'b0;
            o_empty       <= 1'b1;
            o_frames_sent <= FRAMES_INIT;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            hold_q  <= hold_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            o_txd   <= txd_d;
            o_busy  <= busy_d;
            o_empty <= (count_nxt == '0) & ~busy_d;
            if (frame_done && (o_frames_sent != 16'hFFFF)) begin
                o_frames_sent <= o_frames_sent + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_zap_uart_stim_tx.sv
// tb_zap_uart_stim_tx: bench for zap_uart_stim_tx.
// Five instances with different frame formats, decoded by a UART receiver model.
module tb_zap_uart_stim_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  dat    [5];
    logic        valid  [5];
    logic        ready  [5];
    logic        txd    [5];
    logic        busy   [5];
    logic        empty  [5];
    logic [15:0] frames [5];

    int n_cmp = 0;
    int n_bad = 0;
    int acc   [5];

    logic [7:0] expq [$];

    typedef struct {
        int         ch;
        logic [7:0] d;
        logic       par;
    } vec_t;

    vec_t tbl [21];

    always #5 clk = ~clk;

    zap_uart_stim_tx #(.IDLE_BITS(0)) u0 (
        .i_clk(clk), .i_reset(rst), .i_dat(dat[0]), .i_valid(valid[0]),
        .o_ready(ready[0]), .o_txd(txd[0]), .o_busy(busy[0]),
        .o_empty(empty[0]), .o_frames_sent(frames[0]));

    zap_uart_stim_tx #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1),
        .STOP_BITS(2), .IDLE_BITS(0)) u1 (
        .i_clk(clk), .i_reset(rst), .i_dat(dat[1][6:0]), .i_valid(valid[1]),
        .o_ready(ready[1]), .o_txd(txd[1]), .o_busy(busy[1]),
        .o_empty(empty[1]), .o_frames_sent(frames[1]));

    zap_uart_stim_tx #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0),
        .STOP_BITS(2), .IDLE_BITS(0)) u2 (
        .i_clk(clk), .i_reset(rst), .i_dat(dat[2][6:0]), .i_valid(valid[2]),
        .o_ready(ready[2]), .o_txd(txd[2]), .o_busy(busy[2]),
        .o_empty(empty[2]), .o_frames_sent(frames[2]));

    zap_uart_stim_tx #(.FIFO_DEPTH(4), .IDLE_BITS(255)) u3 (
        .i_clk(clk), .i_reset(rst), .i_dat(dat[3]), .i_valid(valid[3]),
        .o_ready(ready[3]), .o_txd(txd[3]), .o_busy(busy[3]),
        .o_empty(empty[3]), .o_frames_sent(frames[3]));

    zap_uart_stim_tx #(.CLKS_PER_BIT(2), .IDLE_BITS(0),
        .FRAMES_INIT(16'hFFFE)) u4 (
        .i_clk(clk), .i_reset(rst), .i_dat(dat[4]), .i_valid(valid[4]),
        .o_ready(ready[4]), .o_txd(txd[4]), .o_busy(busy[4]),
        .o_empty(empty[4]), .o_frames_sent(frames[4]));

    // Scoreboard: every accepted byte is expected on the line in order.
    always @(negedge clk) begin
        for (int c = 0; c < 5; c++) begin
            if (!rst && valid[c] === 1'b1 && ready[c] === 1'b1) begin
                expq.push_back(dat[c]);
                acc[c] = acc[c] + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            valid[c] = 1'b0;
            dat[c]   = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        expq.delete();
        for (int c = 0; c < 5; c++) acc[c] = 0;
    endtask

    task automatic rx_frame(input int ch, input int cpb, input int nb,
                            input int pe, input int ns, input int budget,
                            output bit found, output logic [7:0] d,
                            output logic p, output bit ok);
        int w;
        found = 1'b0;
        d     = 8'h00;
        p     = 1'b0;
        ok    = 1'b1;
        w     = 0;
        while (!found && w < budget) begin
            @(negedge clk);
            w++;
            if (txd[ch] === 1'b0) found = 1'b1;
        end
        if (found) begin
            repeat (cpb / 2) @(negedge clk);
            if (txd[ch] !== 1'b0) ok = 1'b0;
            for (int i = 0; i < nb; i++) begin
                repeat (cpb) @(negedge clk);
                d[i] = txd[ch];
            end
            if (pe != 0) begin
                repeat (cpb) @(negedge clk);
                p = txd[ch];
            end
            for (int s = 0; s < ns; s++) begin
                repeat (cpb) @(negedge clk);
                if (txd[ch] !== 1'b1) ok = 1'b0;
            end
        end
    endtask

    task automatic sb_check(input string nm, input bit found,
                            input logic [7:0] d, input bit ok);
        logic [7:0] e;
        if (!found) begin
            chk({nm, "_timeout"}, 0, 1);
        end else if (expq.size() == 0) begin
            chk({nm, "_sb_empty"}, 0, 1);
        end else begin
            e = expq.pop_front();
            chk({nm, "_data"}, d, e);
            chk({nm, "_framing"}, ok, 1);
        end
    endtask

    task automatic run_group(input string nm, input int first, input int n,
                             input int cpb, input int nb, input int pe,
                             input int ns, input int exp_busy);
        int ch;
        ch = tbl[first].ch;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    dat[ch]   = tbl[first + i].d;
                    valid[ch] = 1'b1;
                    @(posedge clk);
                    #1;
                end
                valid[ch] = 1'b0;
            end
            begin
                bit         f;
                bit         ok;
                logic [7:0] d;
                logic       p;
                for (int i = 0; i < n; i++) begin
                    rx_frame(ch, cpb, nb, pe, ns, 20000, f, d, p, ok);
                    sb_check(nm, f, d, ok);
                    if (f && pe != 0) chk({nm, "_parity"}, p, tbl[first + i].par);
                end
            end
            begin
                int bc;
                int w;
                bc = 0;
                w  = 0;
                while (busy[ch] !== 1'b1 && w < 1000) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                while (busy[ch] === 1'b1 && bc < 30000) begin
                    bc++;
                    @(posedge clk);
                    #1;
                end
                chk({nm, "_busy_cycles"}, bc, exp_busy);
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk({nm, "_empty_after"}, empty[ch], 1);
    endtask

    function automatic logic exp_8n1(input logic [7:0] d, input int k);
        int idx;
        idx = (k - 1) / 16;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        return 1'b1;
    endfunction

    initial begin
        string      s;
        int         errs;
        int         bhi;
        int         bfirst;
        int         k;
        int         first_start;
        int         ready_rise;
        int         lows;
        bit         f;
        bit         ok;
        logic [7:0] d;
        logic       p;

        s = "DLROW OLLEH ";
        for (int i = 0; i < 12; i++) tbl[i] = '{0, s[i], 1'b0};
        tbl[12] = '{1, 8'h55, 1'b1};
        tbl[13] = '{1, 8'h7F, 1'b0};
        tbl[14] = '{1, 8'h03, 1'b1};
        tbl[15] = '{2, 8'h55, 1'b0};
        tbl[16] = '{2, 8'h7F, 1'b1};
        tbl[17] = '{2, 8'h03, 1'b0};
        tbl[18] = '{4, 8'hA5, 1'b0};
        tbl[19] = '{4, 8'h3C, 1'b0};
        tbl[20] = '{4, 8'hFF, 1'b0};

        for (int c = 0; c < 5; c++) begin
            valid[c] = 1'b0;
            dat[c]   = 8'h00;
            acc[c]   = 0;
        end

        // reset values, sampled while reset is held
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("rst_txd%0d", c), txd[c], 1);
            chk($sformatf("rst_busy%0d", c), busy[c], 0);
            chk($sformatf("rst_empty%0d", c), empty[c], 1);
            chk($sformatf("rst_ready%0d", c), ready[c], 1);
            chk($sformatf("rst_frames%0d", c), frames[c],
                (c == 4) ? 32'hFFFE : 32'h0);
        end

        // single 8N1 frame, cycle-exact waveform
        do_reset();
        dat[0]   = 8'h48;
        valid[0] = 1'b1;
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        errs   = (txd[0] !== 1'b1) ? 1 : 0;
        bhi    = 0;
        bfirst = 0;
        for (int kk = 1; kk <= 176; kk++) begin
            @(posedge clk);
            #1;
            if (txd[0] !== exp_8n1(8'h48, kk)) errs++;
            if (busy[0] === 1'b1) begin
                bhi++;
                if (bfirst == 0) bfirst = kk;
            end
        end
        chk("t1_txd_wave_errs", errs, 0);
        chk("t1_busy_cycles", bhi, 160);
        chk("t1_busy_first", bfirst, 1);
        chk("t1_frames", frames[0], 1);
        chk("t1_empty", empty[0], 1);

        // 12 back-to-back frames
        do_reset();
        run_group("t2", 0, 12, 16, 8, 0, 1, 1920);
        chk("t2_frames", frames[0], 12);

        // 7 data bits, parity, 2 stop bits
        do_reset();
        run_group("t3odd", 12, 3, 16, 7, 1, 2, 528);
        chk("t3odd_frames", frames[1], 3);
        run_group("t3even", 15, 3, 16, 7, 1, 2, 528);
        chk("t3even_frames", frames[2], 3);

        // FIFO full during power-on hold-off
        do_reset();
        dat[3]      = 8'h11;
        valid[3]    = 1'b1;
        k           = 0;
        first_start = 0;
        ready_rise  = 0;
        while (first_start == 0 && k < 4200) begin
            @(posedge clk);
            #1;
            k++;
            if (k < 6) dat[3] = 8'(8'h11 * (k + 1));
            if (k == 6) valid[3] = 1'b0;
            if (k == 4) chk("t4_ready_full", ready[3], 0);
            if (txd[3] === 1'b0) first_start = k;
            if (k > 4 && ready[3] === 1'b1 && ready_rise == 0) ready_rise = k;
        end
        chk("t4_accepted", acc[3], 4);
        chk("t4_first_start", first_start, 255 * 16 + 1);
        chk("t4_ready_rise", ready_rise, 255 * 16 + 1);
        for (int i = 0; i < 4; i++) begin
            rx_frame(3, 16, 8, 0, 1, 200, f, d, p, ok);
            sb_check("t4", f, d, ok);
        end
        repeat (16) @(posedge clk);
        #1;
        chk("t4_frames", frames[3], 4);
        chk("t4_empty", empty[3], 1);

        // asynchronous reset in the middle of the second frame
        do_reset();
        for (int i = 0; i < 3; i++) begin
            dat[0]   = 8'h41 + 8'(i);
            valid[0] = 1'b1;
            @(posedge clk);
            #1;
        end
        valid[0] = 1'b0;
        repeat (237) @(posedge clk);
        #1;
        chk("t5_pre_frames", frames[0], 1);
        chk("t5_pre_busy", busy[0], 1);
        chk("t5_pre_txd", txd[0], 0);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_txd", txd[0], 1);
        chk("t5_busy", busy[0], 0);
        chk("t5_empty", empty[0], 1);
        chk("t5_ready", ready[0], 1);
        chk("t5_frames", frames[0], 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expq.delete();
        lows = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (txd[0] !== 1'b1 || busy[0] !== 1'b0) lows++;
        end
        chk("t5_quiet_after", lows, 0);
        chk("t5_frames_after", frames[0], 0);
        fork
            begin
                dat[0]   = 8'h5A;
                valid[0] = 1'b1;
                @(posedge clk);
                #1;
                valid[0] = 1'b0;
            end
            begin
                rx_frame(0, 16, 8, 0, 1, 100, f, d, p, ok);
                sb_check("t5_new", f, d, ok);
            end
        join
        repeat (20) @(posedge clk);
        #1;
        chk("t5_new_frames", frames[0], 1);

        // frame counter saturation
        do_reset();
        chk("t6_init", frames[4], 16'hFFFE);
        run_group("t6a", 18, 1, 2, 8, 0, 1, 20);
        chk("t6_after1", frames[4], 16'hFFFF);
        run_group("t6b", 19, 2, 2, 8, 0, 1, 40);
        chk("t6_after3", frames[4], 16'hFFFF);

        chk("sb_leftover", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/zap_uart_stim_tx.md
Name: zap_uart_stim_tx

Overview:
- Parametrised, self-timed UART serial stimulus transmitter for SoC benches.
- Drives a UART RXD line from a byte FIFO with programmable frame format, bit period and power-on idle hold-off.
- Generalises the fixed 8N1, clock-divider, single-string bench driver.
- One instance per UART channel; each instance's o_txd connects to a zap_soc UARTn_RXD pin.

Parameters:
CLKS_PER_BIT, 16, i_clk cycles per serial bit; legal range >= 2.
DATA_BITS, 8, data bits per frame; legal range 5..8.
PARITY_EN, 0, 1 inserts one parity bit after the data bits.
PARITY_ODD, 0, 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.
FIFO_DEPTH, 16, byte FIFO entries; power of two, >= 2.
IDLE_BITS, 255, bit periods of forced idle after reset before the first start bit; 0 disables the hold-off.

Ports:
i_clk  in  1  single clock.
i_reset  in  1  asynchronous active-high reset.
i_dat  in  DATA_BITS  byte to transmit.
i_valid  in  1  push request.
o_ready  out  1  FIFO can accept; push occurs on a rising edge with i_valid & o_ready.
o_txd  out  1  serial line; idles high.
o_busy  out  1  high while a frame is in flight.
o_empty  out  1  FIFO empty and no frame in flight.
o_frames_sent  out  16  count of completed frames; saturates at 16'hFFFF.

Behaviour:
- Reset (asynchronous, active-high), applied immediately, including mid-frame:
  - o_txd=1, o_busy=0, o_empty=1, o_ready=1, o_frames_sent=0.
  - FIFO cleared; state=HOLD, or IDLE when IDLE_BITS=0.
  - Bit timer and bit counters = 0.
- o_ready = (fifo_count < FIFO_DEPTH), combinational from the count only.
  - When full, a push is ignored.
  - When not full, a push and a pop on the same edge leave the count unchanged.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
  - A bit boundary occurs when the timer equals CLKS_PER_BIT-1; the timer then wraps to 0.
  - Every serial bit is held exactly CLKS_PER_BIT cycles.
- State machine:
  - HOLD:
    - o_txd=1; counts IDLE_BITS bit periods, then -> IDLE.
    - Pushes are accepted during HOLD; nothing is transmitted.
  - IDLE:
    - o_txd=1, timer held at 0.
    - If the FIFO is non-empty: pop into the shift register on this edge, o_txd<=0, o_busy<=1, -> START.
  - START: after one bit period -> DATA; o_txd<=shift[0].
  - DATA:
    - LSB first; shift right at each bit boundary.
    - After DATA_BITS periods: -> PAR if PARITY_EN, else -> STOP.
  - PAR:
    - o_txd = XOR of the frame's data bits, inverted when PARITY_ODD.
    - Parity is computed at pop time.
  - STOP:
    - o_txd=1 for STOP_BITS periods.
    - On the final boundary, o_frames_sent increments (saturating).
    - If the FIFO is non-empty on that same edge: pop, o_txd<=0, -> START. Back-to-back frames have no idle gap.
    - Otherwise: o_busy<=0, -> IDLE.
- Latency: push at edge N into an empty FIFO in IDLE -> start bit is driven from edge N+1.
- Frame length: (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- o_empty = (fifo_count==0) & ~o_busy, registered.
- Data bits of i_dat above DATA_BITS do not exist (the port is DATA_BITS wide); no truncation logic.

Test Plan:
- Default 8N1, CLKS_PER_BIT=16, IDLE_BITS=0; push 8'h48 -> o_txd low 16 cycles starting edge N+1, then bits 0,0,0,1,0,0,1,0 at 16 cycles each, then high 16 cycles; o_frames_sent=1; o_busy high exactly 160 cycles.
- Push the 12 bytes of "DLROW OLLEH " in consecutive cycles -> 12 frames back-to-back with no idle gap (1920 cycles total); decoded bytes match in order; o_frames_sent=12; o_empty=1 afterwards.
- PARITY_EN=1, PARITY_ODD=1, DATA_BITS=7, STOP_BITS=2; push 7'h55 -> parity bit 1, two stop periods, 11 bit periods per frame; repeat with PARITY_ODD=0 -> parity bit 0.
- FIFO_DEPTH=4, IDLE_BITS=255; push 6 bytes with i_valid held high -> 4 accepted, o_ready=0 until the first pop at the hold-off end (255*16 cycles after reset); no start bit before then.
- Assert i_reset in the middle of DATA of the second of 3 queued frames -> o_txd=1 in the same cycle, FIFO emptied, o_frames_sent=0, o_busy=0; after release, no frames are sent until a new push.
- Force o_frames_sent to 16'hFFFE via 65534 frames, or via a test hook, and send 3 more frames -> count stops at 16'hFFFF.
